// File: rtl/data_sram_responder.sv
// Data-SRAM responder: executes one load/store at a time against an internal
// word-addressed array and returns the result after LATENCY cycles, holding
// the response until the consumer takes it.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_wr,
    output logic        resp_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // WAIT counts down from LATENCY-2 so that RESP is reached after LATENCY-1 edges.
    localparam logic [3:0] LAT_M2 = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_resp_rdata;
    logic        r_resp_wr;
    logic        r_resp_err;
    logic [31:0] r_mem [0:DEPTH-1];

    logic [31:0]       w_addr_word;
    logic [ADDR_W-1:0] w_idx;
    logic              w_oor;
    logic              w_accept;
    logic              w_resp_xfer;

    // Byte offset bits are dropped; anything above the index bits means out of range.
    assign w_addr_word = req_addr >> 2;
    assign w_idx       = w_addr_word[ADDR_W-1:0];
    assign w_oor       = |(w_addr_word >> ADDR_W);

    assign resp_valid  = (r_state == ST_RESP);
    assign req_ready   = ~reset & ((r_state == ST_IDLE) | ((r_state == ST_RESP) & resp_ready));
    assign w_accept    = req_valid & req_ready;
    assign w_resp_xfer = resp_valid & resp_ready;

    assign resp_rdata  = r_resp_rdata;
    assign resp_wr     = r_resp_wr;
    assign resp_err    = r_resp_err;

    // Next-state and latency-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            // Acceptance is possible from IDLE or from RESP while the response is taken.
            if (LATENCY == 1) begin
                w_state_nxt = ST_RESP;
            end else begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = LAT_M2;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Response registers: capture on acceptance, clear when taken with nothing new.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_rdata <= 32'd0;
            r_resp_wr    <= 1'b0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            // Read happens before any same-edge write, but only one request exists per edge.
            r_resp_rdata <= (req_wr || w_oor) ? 32'd0 : r_mem[w_idx];
            r_resp_wr    <= req_wr;
            r_resp_err   <= w_oor;
        end else if (w_resp_xfer) begin
            r_resp_rdata <= 32'd0;
            r_resp_wr    <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_rdata <= r_resp_rdata;
            r_resp_wr    <= r_resp_wr;
            r_resp_err   <= r_resp_err;
        end
    end

    // Byte-masked array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_wr && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances with LATENCY 1, 4 and 3.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic [2:0]  reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_wr;
    logic [3:0]  req_wstrb [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [2:0]  resp_valid;
    logic [2:0]  resp_ready;
    logic [31:0] resp_rdata [3];
    logic [2:0]  resp_wr;
    logic [2:0]  resp_err;

    int total = 0;
    int bad   = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_sram_responder #(
            .ADDR_W (10),
            .LATENCY((g == 0) ? 1 : ((g == 1) ? 4 : 3))
        ) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wr    (req_wr[g]),
            .req_wstrb (req_wstrb[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_wr   (resp_wr[g]),
            .resp_err  (resp_err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input logic wr, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_wstrb[d] = strb;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
    endtask

    // One request from IDLE, wait for its response, check it and consume it.
    task automatic xfer(input int d, input logic wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input string tag);
        int n;
        set_req(d, wr, strb, addr, wdata);
        resp_ready[d] = 1'b1;
        chk({tag, "_rdy"}, 32'(req_ready[d]), 32'd1);
        cyc();
        req_valid[d] = 1'b0;
        n = 1;
        while (!resp_valid[d] && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_lat"},   32'(n), 32'(lat));
        chk({tag, "_rdata"}, resp_rdata[d], exp_rd);
        chk({tag, "_wr"},    32'(resp_wr[d]), 32'(wr));
        chk({tag, "_err"},   32'(resp_err[d]), 32'(exp_err));
        cyc();
        chk({tag, "_vld0"},  32'(resp_valid[d]), 32'd0);
        chk({tag, "_clr"},   resp_rdata[d], 32'd0);
    endtask

    initial begin
        reset      = 3'b111;
        req_valid  = 3'b000;
        req_wr     = 3'b000;
        resp_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            req_wstrb[i] = 4'h0;
            req_addr[i]  = 32'h0;
            req_wdata[i] = 32'h0;
        end
        cyc();
        cyc();
        chk("rst_rdy_low", 32'(req_ready), 32'd0);
        reset = 3'b000;
        #1;
        chk("rst_vld",   32'(resp_valid), 32'd0);
        chk("rst_wr",    32'(resp_wr), 32'd0);
        chk("rst_err",   32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'd0);
        chk("rst_rdy",   32'(req_ready), 32'd7);

        // Full store with LATENCY 1, response held one cycle before being taken.
        set_req(0, 1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
        cyc();
        req_valid[0] = 1'b0;
        chk("st1_vld",   32'(resp_valid[0]), 32'd1);
        chk("st1_wr",    32'(resp_wr[0]), 32'd1);
        chk("st1_err",   32'(resp_err[0]), 32'd0);
        chk("st1_rdata", resp_rdata[0], 32'd0);
        resp_ready[0] = 1'b1;
        cyc();
        chk("st1_vld0",  32'(resp_valid[0]), 32'd0);
        xfer(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1122_3344, 1'b0, 1, "ld1");

        // Partial store: bytes 0 and 2 replaced.
        xfer(0, 1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD, 32'h0, 1'b0, 1, "st2");
        xfer(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h11BB_33DD, 1'b0, 1, "ld2");
        xfer(0, 1'b0, 4'h0, 32'h0000_0013, 32'h0, 32'h11BB_33DD, 1'b0, 1, "ld2u");

        // LATENCY 4, then a 3-cycle stall with a competing request that must be ignored.
        xfer(1, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b0, 4, "st4");
        set_req(1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        resp_ready[1] = 1'b0;
        cyc();
        chk("ld4_wait_rdy", 32'(req_ready[1]), 32'd0);
        req_valid[1] = 1'b0;
        cyc();
        cyc();
        chk("ld4_pre_vld", 32'(resp_valid[1]), 32'd0);
        cyc();
        chk("ld4_vld", 32'(resp_valid[1]), 32'd1);
        set_req(1, 1'b1, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_vld",   32'(resp_valid[1]), 32'd1);
            chk("stall_rdata", resp_rdata[1], 32'h1234_5678);
            chk("stall_rdy",   32'(req_ready[1]), 32'd0);
        end
        req_valid[1]  = 1'b0;
        resp_ready[1] = 1'b1;
        cyc();
        chk("stall_done", 32'(resp_valid[1]), 32'd0);
        xfer(1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0, 4, "ld4b");

        // Back-to-back store/load pairs, one response per cycle.
        resp_ready[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_req(0, (k % 2 == 0), 4'hF, 32'h0000_0100 + 32'(4 * (k / 2)),
                    32'h5A00_0000 + 32'(k / 2) * 32'h0000_0101);
            cyc();
            chk("b2b_vld", 32'(resp_valid[0]), 32'd1);
            chk("b2b_wr",  32'(resp_wr[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("b2b_rdata", resp_rdata[0],
                (k % 2 == 0) ? 32'd0 : 32'h5A00_0000 + 32'(k / 2) * 32'h0000_0101);
        end
        req_valid[0] = 1'b0;
        cyc();
        chk("b2b_end", 32'(resp_valid[0]), 32'd0);

        // Out-of-range accesses; 0x1000 aliases word 0 if the range check is wrong.
        xfer(0, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 1'b0, 1, "st0");
        xfer(0, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1, "oor_ld");
        xfer(0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "oor_st");
        xfer(0, 1'b0, 4'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1, "oor_hi");
        xfer(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1'b0, 1, "ld0");

        // Reset during WAIT (LATENCY 3) after a store; the store must stay committed.
        set_req(2, 1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF);
        resp_ready[2] = 1'b1;
        cyc();
        chk("rw_wait_vld", 32'(resp_valid[2]), 32'd0);
        set_req(2, 1'b1, 4'hF, 32'h0000_0020, 32'h0000_0000);
        reset[2] = 1'b1;
        #1;
        chk("rw_rst_rdy", 32'(req_ready[2]), 32'd0);
        cyc();
        reset[2]     = 1'b0;
        req_valid[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rw_vld", 32'(resp_valid[2]), 32'd0);
        end
        chk("rw_idle_rdy", 32'(req_ready[2]), 32'd1);
        xfer(2, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, "rw_ld");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
